// File: rtl/hpm_counter_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hpm_counter_bank : mcycle, minstret and NUM_HPM event counters with CSR access.
// Optional overflow flags / interrupt (CSR 0xDA0) when HPM_OVF_IRQ_EN is defined.
// Revision 1.0
// ----------------------------------------------------------------------------
module hpm_counter_bank #(
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_HPM    = 4,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  csr_re,
  input  logic                  csr_we,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  csr_rvalid,
  output logic                  csr_illegal,
  output logic [CNT_WIDTH-1:0]  mcycle_q,
  output logic [CNT_WIDTH-1:0]  minstret_q,
  output logic                  ovf_irq_o
);
  localparam int c_ncnt = NUM_HPM + 3;
  localparam int c_hw   = CNT_WIDTH - 32;
  localparam logic [c_ncnt-1:0] c_inh_mask = ~c_ncnt'(2);

  logic [CNT_WIDTH-1:0] w_cnt [c_ncnt];
  logic [4:0]           w_sel [c_ncnt];
  logic [c_ncnt-1:0]    w_inc;
  logic [c_ncnt-1:0]    w_wr_lo;
  logic [c_ncnt-1:0]    w_wr_hi;
  logic [c_ncnt-1:0]    r_inhibit;
  logic [31:0]          w_ev_pad;
  logic                 w_rd_hit;
  logic                 w_wr_hit;
  logic [31:0]          w_rd_val;

  // Bit k of the padded vector is event number k; bit 0 and bits above NUM_EVENTS never count.
  assign w_ev_pad = 32'({event_i, 1'b0});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inhibit <= '0;
    end else if (csr_we && csr_addr == 12'h320) begin
      r_inhibit <= csr_wdata[c_ncnt-1:0] & c_inh_mask;
    end
  end

  for (genvar i = 0; i < c_ncnt; i++) begin : g_cnt
    if (i == 1) begin : g_unimpl
      assign w_cnt[i]   = '0;
      assign w_sel[i]   = '0;
      assign w_inc[i]   = 1'b0;
      assign w_wr_lo[i] = 1'b0;
      assign w_wr_hi[i] = 1'b0;
    end else begin : g_impl
      logic [CNT_WIDTH-1:0] r_cnt;
      assign w_wr_lo[i] = csr_we && (csr_addr == 12'hB00 + 12'(i));
      assign w_wr_hi[i] = csr_we && (csr_addr == 12'hB80 + 12'(i));
      if (i == 0) begin : g_cycle
        assign w_sel[i] = '0;
        assign w_inc[i] = ~r_inhibit[i];
      end else if (i == 2) begin : g_instret
        assign w_sel[i] = '0;
        assign w_inc[i] = commit_i & ~r_inhibit[i];
      end else begin : g_hpm
        logic [4:0] r_sel;
        always_ff @(posedge clk) begin
          if (rst) begin
            r_sel <= '0;
          end else if (csr_we && csr_addr == 12'h320 + 12'(i)) begin
            r_sel <= csr_wdata[4:0];
          end
        end
        assign w_sel[i] = r_sel;
        assign w_inc[i] = w_ev_pad[r_sel] & ~r_inhibit[i];
      end
      // A CSR write to either half suppresses that cycle's increment.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_wr_lo[i]) begin
          r_cnt[31:0] <= csr_wdata;
        end else if (w_wr_hi[i]) begin
          r_cnt[CNT_WIDTH-1:32] <= csr_wdata[c_hw-1:0];
        end else if (w_inc[i]) begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
      end
      assign w_cnt[i] = r_cnt;
    end
  end

`ifdef HPM_OVF_IRQ_EN
  logic [c_ncnt-1:0] r_ovf;
  logic [c_ncnt-1:0] w_wrap;
  logic              r_irq;

  always_comb begin
    w_wrap = '0;
    for (int i = 0; i < c_ncnt; i++) begin
      w_wrap[i] = w_inc[i] & ~w_wr_lo[i] & ~w_wr_hi[i] & (&w_cnt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= '0;
      r_irq <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~w_wr_lo) | w_wrap;
      r_irq <= |r_ovf;
    end
  end
  assign ovf_irq_o = r_irq;
`else
  assign ovf_irq_o = 1'b0;
`endif

  always_comb begin
    w_rd_hit = 1'b0;
    w_wr_hit = 1'b0;
    w_rd_val = '0;
    if (csr_addr == 12'h320) begin
      w_rd_hit = 1'b1;
      w_wr_hit = 1'b1;
      w_rd_val = 32'(r_inhibit);
    end
    for (int i = 0; i < c_ncnt; i++) begin
      if (i != 1) begin
        if (csr_addr == 12'hB00 + 12'(i) || csr_addr == 12'hC00 + 12'(i)) begin
          w_rd_hit = 1'b1;
          w_rd_val = w_cnt[i][31:0];
        end
        if (csr_addr == 12'hB80 + 12'(i) || csr_addr == 12'hC80 + 12'(i)) begin
          w_rd_hit = 1'b1;
          w_rd_val = 32'(w_cnt[i][CNT_WIDTH-1:32]);
        end
        if (csr_addr == 12'hB00 + 12'(i) || csr_addr == 12'hB80 + 12'(i)) begin
          w_wr_hit = 1'b1;
        end
      end
      if (i >= 3 && csr_addr == 12'h320 + 12'(i)) begin
        w_rd_hit = 1'b1;
        w_wr_hit = 1'b1;
        w_rd_val = 32'(w_sel[i]);
      end
    end
`ifdef HPM_OVF_IRQ_EN
    if (csr_addr == 12'hDA0) begin
      w_rd_hit = 1'b1;
      w_rd_val = 32'(r_ovf);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csr_rvalid  <= 1'b0;
      csr_rdata   <= '0;
      csr_illegal <= 1'b0;
    end else begin
      csr_rvalid  <= csr_re;
      csr_rdata   <= csr_re ? w_rd_val : 32'd0;
      csr_illegal <= (csr_re && !w_rd_hit) || (csr_we && !w_wr_hit);
    end
  end

  assign mcycle_q   = w_cnt[0];
  assign minstret_q = w_cnt[2];

endmodule
`default_nettype wire
